sprite_scan_engine: RTL
=======================

// Module: sprite_scan_engine
// PURPOSE
//  Parametrised multi-sprite pixel scanner for the VGA plotting path; generalises the fixed 10-enemy 5x5 datapath.
//  Holds N_SPR (x,y) anchors and walks every pixel of each selected sprite, one pixel per clock.
//  Emits coordinate, colour and a plot strobe toward the VGA adapter, with a start/busy/done handshake to the control FSM.
//  Supports a draw/erase mode, skipping invisible sprites, transparency and a parametrised bitmap.
// PARAMETERS
//  N_SPR       10               number of sprites (1..16)
//  SPR_W       5                sprite width in pixels (1..8)
//  SPR_H       5                sprite height in pixels (1..8)
//  COORD_W     8                coordinate width
//  COLOR_W     3                colour width
//  FG_COLOR    3'b111           colour used for set bitmap bits
//  BITMAP      25'h023B6A       SPR_W*SPR_H bits; bit [row*SPR_W+col], bit0 = top-left
//  TRANSPARENT 0                1: plot only set bits; 0: plot every pixel (clear bits drawn black)
// PORTS
//  clk        in   1                  system clock
//  reset_n    in   1                  async active-low reset
//  load_coord in   1                  write all anchors from x_in/y_in
//  x_in       in   N_SPR*COORD_W      packed x anchors, sprite i at [i*COORD_W +: COORD_W]
//  y_in       in   N_SPR*COORD_W      packed y anchors, same packing as x_in
//  visible    in   N_SPR              per-sprite visibility
//  start      in   1                  begin a scan (honoured in IDLE only)
//  erase      in   1                  scan mode, sampled with start: 1 = erase, 0 = draw
//  x_out      out  COORD_W            pixel x
//  y_out      out  COORD_W            pixel y
//  color_out  out  COLOR_W            pixel colour
//  plot       out  1                  x_out/y_out/color_out valid; write this pixel
//  busy       out  1                  scan in progress
//  done       out  1                  1-cycle pulse at end of scan
// BEHAVIOUR
//  Reset (async, any time, including mid-scan):
//   - All anchors, counters and outputs go to 0; FSM goes to IDLE.
//   - plot, busy and done drop immediately.
//  Anchors:
//   - load_coord in IDLE writes all anchors on the clock edge.
//   - load_coord while busy is ignored.
//   - load_coord and start in the same cycle: the scan uses the newly loaded values.
//  Scan start:
//   - start in IDLE latches erase into mode_r and visible into vis_r.
//   - start while busy, or during the done cycle, is ignored.
//  FSM states and transitions:
//   - IDLE -> SCAN on start.
//   - SCAN -> DONE after the last pixel of the last selected sprite.
//   - DONE -> IDLE after one cycle.
//  Sprite selection:
//   - Draw mode: sprite i is visited iff vis_r[i]=1.
//   - Erase mode: every sprite is visited.
//   - Non-visited sprites cost zero cycles; the next selected index is found combinationally.
//  Scan order: ascending sprite index; within a sprite, row-major (col 0..SPR_W-1 inner, row 0..SPR_H-1 outer).
//  Pixel output (registered):
//   - Start seen at edge k -> first pixel on outputs after edge k+1.
//   - One pixel per cycle, no gaps between pixels or between sprites.
//   - Sprite i: x_out = x_i + col and y_out = y_i + row, truncated to COORD_W (wraps mod 2^COORD_W).
//   - Draw mode: color_out = FG_COLOR if the BITMAP bit is set, else 0.
//   - Draw mode, plot: TRANSPARENT=0 -> plot=1 every scan cycle; TRANSPARENT=1 -> plot = bitmap bit.
//   - Erase mode: color_out = 0; plot=1 on every pixel of every visited sprite; TRANSPARENT ignored.
//   - Outside scan cycles: plot=0; x_out/y_out/color_out hold their last value.
//  Handshake:
//   - busy=1 from edge k+1 through the final pixel cycle.
//   - done=1 for exactly the cycle after the final pixel; busy=0 during done.
//   - Scan length = V*SPR_W*SPR_H cycles, V = number of visited sprites.
//   - V=0 (draw mode, vis_r all zero): no plot; done pulses in cycle k+1; busy stays 0.
//  visible and erase changes during a scan have no effect.
// TESTING
//  1. Assert reset_n=0 mid-idle -> x_out/y_out/color_out/plot/busy/done all 0.
//  2. Draw, default params, visible=10'h001, x0=10, y0=20, start:
//     -> 25 plot cycles; pixel0 (10,20) colour 0; pixel1 (11,20) colour 7;
//        pixel5 (10,21) colour 7; pixel17 (12,23) colour 7;
//     -> done 1 cycle after pixel24.
//  3. Draw, visible=10'h201 -> 50 contiguous plot cycles: sprite0 pixels, then sprite9 pixels directly after.
//  4. Erase, visible=0 -> 250 plot cycles, all colour 0; then done.
//  5. x0=254, y0=255, visible=1, draw -> row0 x_out 254,255,0,1,2; row1 y_out=0 (wrap).
//  6. Reset mid-scan, then restart:
//     - reset_n low at pixel 7 -> plot/busy 0 immediately.
//     - After release, reload anchors and start -> scan restarts at sprite0 pixel0.
//     - A second start during busy -> ignored; total plot count unchanged.
//  7. TRANSPARENT=1, visible=1, draw -> exactly 10 plot pulses over 25 cycles, each colour 7.

Source files
------------

// File: rtl/sprite_scan_engine.sv
// Multi-sprite pixel scanner: walks every pixel of each selected sprite, one pixel per clock,
// and emits coordinate, colour and a plot strobe toward the VGA adapter.
module sprite_scan_engine #(
    parameter int unsigned             N_SPR       = 10,
    parameter int unsigned             SPR_W       = 5,
    parameter int unsigned             SPR_H       = 5,
    parameter int unsigned             COORD_W     = 8,
    parameter int unsigned             COLOR_W     = 3,
    parameter logic [COLOR_W-1:0]      FG_COLOR    = 3'b111,
    parameter logic [SPR_W*SPR_H-1:0]  BITMAP      = 25'h023B6A,
    parameter bit                      TRANSPARENT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_coord,
    input  logic [N_SPR*COORD_W-1:0]   x_in,
    input  logic [N_SPR*COORD_W-1:0]   y_in,
    input  logic [N_SPR-1:0]           visible,
    input  logic                       start,
    input  logic                       erase,
    output logic [COORD_W-1:0]         x_out,
    output logic [COORD_W-1:0]         y_out,
    output logic [COLOR_W-1:0]         color_out,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned IdxW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int unsigned ColW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RowW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e              state_q;
    logic [COORD_W-1:0]  ax_q [N_SPR];
    logic [COORD_W-1:0]  ay_q [N_SPR];
    logic                mode_q;
    logic [N_SPR-1:0]    vis_q;
    logic [IdxW-1:0]     spr_q;
    logic [ColW-1:0]     col_q;
    logic [RowW-1:0]     row_q;
    logic [COORD_W-1:0]  x_q, y_q;
    logic [COLOR_W-1:0]  color_q;
    logic                plot_q, busy_q, done_q;

    logic [N_SPR-1:0]    sel_start, sel_scan;
    logic                first_found, next_found;
    logic [IdxW-1:0]     first_idx, next_idx;
    logic                pix_bit, pix_plot, last_col, last_row;
    logic [COORD_W-1:0]  pix_x, pix_y;
    logic [COLOR_W-1:0]  pix_color;

    // Erase mode visits every sprite; draw mode only the visible ones.
    assign sel_start = erase ? {N_SPR{1'b1}} : visible;
    assign sel_scan  = mode_q ? {N_SPR{1'b1}} : vis_q;

    // Lowest selected sprite for the start of a scan (descending loop so the lowest wins).
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (sel_start[i]) begin
                first_found = 1'b1;
                first_idx   = IdxW'(i);
            end
        end
    end

    // Next selected sprite above the current one, so unselected sprites cost no cycles.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (sel_scan[i] && (IdxW'(i) > spr_q)) begin
                next_found = 1'b1;
                next_idx   = IdxW'(i);
            end
        end
    end

    // Bitmap lookup for the current (row, col) and the resulting pixel attributes.
    always_comb begin
        pix_bit = 1'b0;
        for (int r = 0; r < SPR_H; r++) begin
            for (int c = 0; c < SPR_W; c++) begin
                if ((row_q == RowW'(r)) && (col_q == ColW'(c))) begin
                    pix_bit = BITMAP[r*SPR_W+c];
                end
            end
        end
        pix_x     = ax_q[spr_q] + COORD_W'(col_q);
        pix_y     = ay_q[spr_q] + COORD_W'(row_q);
        pix_color = (!mode_q && pix_bit) ? FG_COLOR : '0;
        pix_plot  = mode_q ? 1'b1 : (TRANSPARENT ? pix_bit : 1'b1);
        last_col  = (col_q == ColW'(SPR_W - 1));
        last_row  = (row_q == RowW'(SPR_H - 1));
    end

    // Scan FSM with registered pixel and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            for (int i = 0; i < N_SPR; i++) begin
                ax_q[i] <= '0;
                ay_q[i] <= '0;
            end
            mode_q  <= 1'b0;
            vis_q   <= '0;
            spr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (load_coord) begin
                        for (int i = 0; i < N_SPR; i++) begin
                            ax_q[i] <= x_in[i*COORD_W +: COORD_W];
                            ay_q[i] <= y_in[i*COORD_W +: COORD_W];
                        end
                    end
                    // done_q still high means we are in the done cycle: ignore start.
                    if (start && !done_q) begin
                        mode_q  <= erase;
                        vis_q   <= visible;
                        spr_q   <= first_idx;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= first_found ? StScan : StDone;
                    end
                end
                StScan: begin
                    x_q     <= pix_x;
                    y_q     <= pix_y;
                    color_q <= pix_color;
                    plot_q  <= pix_plot;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    if (last_col) begin
                        col_q <= '0;
                        if (last_row) begin
                            row_q <= '0;
                            if (next_found) begin
                                spr_q <= next_idx;
                            end else begin
                                state_q <= StDone;
                            end
                        end else begin
                            row_q <= row_q + RowW'(1);
                        end
                    end else begin
                        col_q <= col_q + ColW'(1);
                    end
                end
                StDone: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign color_out = color_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
